// File: rtl/ring_peak_pkg.sv
// Shared definitions for the ring peak detector.
// Holds the default parameter values, the per-ring state enumeration and a
// constant clog2 helper used to size ports and pointers.
package ring_peak_pkg;

  localparam int DATA_W_DEFAULT        = 10;
  localparam int CH_W_DEFAULT          = 6;
  localparam int RINGS_DEFAULT         = 8;
  localparam int DEPTH_DEFAULT         = 8;
  localparam int HYST_DEFAULT          = 16;
  localparam int THRES_DEFAULT_VALUE   = 510;

  // A ring is either waiting for a crossing (ARMED) or riding above its
  // threshold until the sample drops below the hysteresis band (IN_PEAK).
  typedef enum logic {
    ARMED   = 1'b0,
    IN_PEAK = 1'b1
  } ring_state_e;

  // Ceiling log2 usable in constant expressions (parameter and port sizing).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   push, wdata     - write request and data (ignored while full)
//   pop, rdata      - read request (ignored while empty) and head-of-queue data
//   full, empty     - occupancy flags derived from count
//   count           - current number of stored words
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import ring_peak_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head of queue is read straight out of the storage array; a word written
  // at an edge only becomes visible here after that edge, so there is no
  // same-cycle bypass from wdata to rdata.
  assign rdata = mem[rd_ptr];

  // Storage array carries no reset: stale words are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping. A simultaneous push and pop moves both
  // pointers and leaves the count where it was.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ring_peak_detector.sv
// Per-ring peak detector with hysteresis.
// Incoming {channel, sample} words are queued in a FIFO, then evaluated one
// per cycle against the threshold of the ring selected by the channel's top
// bits. An ARMED ring that sees a sample strictly above its threshold emits
// one event and goes IN_PEAK; it re-arms silently once a sample falls below
// threshold minus HYST (floored at zero).
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   in_valid, in_ready, in_word      - input stream, in_word = {channel, sample}
//   cfg_we, cfg_ring, cfg_thres      - threshold write (also re-arms the ring)
//   evt_valid, evt_ready             - registered event output handshake
//   evt_ring, evt_channel, evt_value - event payload
//   fifo_count                       - current input FIFO occupancy
//   peak_count                       - saturating count of emitted events
module ring_peak_detector
  import ring_peak_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int CH_W          = CH_W_DEFAULT,
  parameter int RINGS         = RINGS_DEFAULT,
  parameter int DEPTH         = DEPTH_DEFAULT,
  parameter int HYST          = HYST_DEFAULT,
  parameter int THRES_DEFAULT = THRES_DEFAULT_VALUE,
  localparam int RING_W = clog2(RINGS),
  localparam int CNT_W  = clog2(DEPTH) + 1,
  localparam int WORD_W = CH_W + DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              cfg_we,
  input  logic [RING_W-1:0] cfg_ring,
  input  logic [DATA_W-1:0] cfg_thres,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [RING_W-1:0] evt_ring,
  output logic [CH_W-1:0]   evt_channel,
  output logic [DATA_W-1:0] evt_value,
  output logic [CNT_W-1:0]  fifo_count,
  output logic [15:0]       peak_count
);

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rdata;

  logic [CH_W-1:0]   pop_channel;
  logic [DATA_W-1:0] pop_sample;
  logic [RING_W-1:0] pop_ring;

  ring_state_e       ring_state      [RINGS];
  ring_state_e       ring_state_next [RINGS];
  logic [DATA_W-1:0] thres           [RINGS];

  ring_state_e       sel_state;
  logic [DATA_W-1:0] sel_thres;
  logic [DATA_W:0]   rearm_diff;
  logic [DATA_W-1:0] rearm_level;
  logic              fire;
  logic              rearm;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  // A word leaves the FIFO only when the event register is free or is being
  // handed off this very edge, so a stalled consumer back-pressures the queue.
  assign fifo_pop = !fifo_empty && !(evt_valid && !evt_ready);

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop_channel = fifo_rdata[WORD_W-1 -: CH_W];
  assign pop_sample  = fifo_rdata[DATA_W-1:0];
  assign pop_ring    = pop_channel[CH_W-1 -: RING_W];
  assign sel_state   = ring_state[pop_ring];
  assign sel_thres   = thres[pop_ring];

  // Evaluation of the popped word. The re-arm level is formed one bit wider
  // than the sample so a threshold below HYST shows up as a borrow and clamps
  // the level to zero (no sample can then re-arm the ring).
  always_comb begin
    rearm_diff  = {1'b0, sel_thres} - (DATA_W+1)'(HYST);
    rearm_level = rearm_diff[DATA_W] ? '0 : rearm_diff[DATA_W-1:0];
    fire        = fifo_pop && (sel_state == ARMED) && (pop_sample > sel_thres);
    rearm       = fifo_pop && (sel_state == IN_PEAK) && (pop_sample < rearm_level);
  end

  // Next ring states. A config write is applied last so it always leaves its
  // ring ARMED, even when that ring fired in the same cycle.
  always_comb begin
    for (int i = 0; i < RINGS; i++) begin
      ring_state_next[i] = ring_state[i];
    end
    if (fire) begin
      ring_state_next[pop_ring] = IN_PEAK;
    end else if (rearm) begin
      ring_state_next[pop_ring] = ARMED;
    end
    if (cfg_we) begin
      ring_state_next[cfg_ring] = ARMED;
    end
  end

  // Ring state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RINGS; i++) begin
        ring_state[i] <= ARMED;
      end
    end else begin
      for (int i = 0; i < RINGS; i++) begin
        ring_state[i] <= ring_state_next[i];
      end
    end
  end

  // Threshold registers. Evaluation this cycle reads the pre-write value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RINGS; i++) begin
        thres[i] <= DATA_W'(THRES_DEFAULT);
      end
    end else if (cfg_we) begin
      thres[cfg_ring] <= cfg_thres;
    end
  end

  // Event output register. A held event is released on handshake, and a new
  // one may be loaded at that same edge, giving one event per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid   <= 1'b0;
      evt_ring    <= '0;
      evt_channel <= '0;
      evt_value   <= '0;
    end else begin
      if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (fire) begin
        evt_valid   <= 1'b1;
        evt_ring    <= pop_ring;
        evt_channel <= pop_channel;
        evt_value   <= pop_sample;
      end
    end
  end

  // Saturating event counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_count <= '0;
    end else if (fire && (peak_count != 16'hFFFF)) begin
      peak_count <= peak_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ring_peak_detector.sv
// Self-checking bench for ring_peak_detector.
// A behavioural model of the rings runs alongside the stimulus: every accepted
// word is evaluated by the model and any expected event is queued; the monitor
// pops the queue whenever the DUT completes an event handshake.
module tb_ring_peak_detector;

  typedef struct packed {
    logic [2:0] ring;
    logic [5:0] channel;
    logic [9:0] value;
  } evt_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_word = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_ring = '0;
  logic [9:0]  cfg_thres = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [2:0]  evt_ring;
  logic [5:0]  evt_channel;
  logic [9:0]  evt_value;
  logic [3:0]  fifo_count;
  logic [15:0] peak_count;

  int   assertCount = 0;
  int   failCount = 0;
  evt_t sb[$];
  bit   mState [8];
  logic [9:0] mThres [8];
  logic [15:0] mPeak;

  always #5 clk = ~clk;

  ring_peak_detector dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .cfg_we      (cfg_we),
    .cfg_ring    (cfg_ring),
    .cfg_thres   (cfg_thres),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ring    (evt_ring),
    .evt_channel (evt_channel),
    .evt_value   (evt_value),
    .fifo_count  (fifo_count),
    .peak_count  (peak_count)
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 8; i++) begin
      mState[i] = 1'b0;
      mThres[i] = 10'd510;
    end
    mPeak = 16'd0;
  endfunction

  // Reference behaviour of one accepted word, evaluated in plain integers.
  function automatic void modelWord(input logic [5:0] ch, input logic [9:0] s);
    int r;
    r = int'(ch[5:3]);
    if (!mState[r] && int'(s) > int'(mThres[r])) begin
      sb.push_back('{ring: ch[5:3], channel: ch, value: s});
      mState[r] = 1'b1;
      if (mPeak != 16'hFFFF) mPeak = mPeak + 16'd1;
    end else if (mState[r] && int'(s) < int'(mThres[r]) - 16) begin
      mState[r] = 1'b0;
    end
  endfunction

  // Offer one word and hold it until the DUT accepts it.
  task automatic applyStimulus(input logic [5:0] ch, input logic [9:0] s);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = {ch, s};
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("push_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    modelWord(ch, s);
    #1 in_valid = 1'b0;
  endtask

  task automatic applyConfig(input logic [2:0] r, input logic [9:0] t);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_ring  = r;
    cfg_thres = t;
    @(posedge clk);
    mThres[r] = t;
    mState[r] = 1'b0;
    #1 cfg_we = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || fifo_count != 0 || evt_valid) && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkOutput(tag, sb.size(), 0);
  endtask

  // Event monitor: a handshake about to complete must match the queue head.
  always begin : monitor
    evt_t e;
    @(negedge clk);
    #1;
    if (!reset && evt_valid && evt_ready) begin
      checkOutput("evt_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("evt_ring", evt_ring, e.ring);
        checkOutput("evt_channel", evt_channel, e.channel);
        checkOutput("evt_value", evt_value, e.value);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    modelReset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_evt_valid", evt_valid, 0);
    checkOutput("rst_evt_value", evt_value, 0);
    checkOutput("rst_evt_channel", evt_channel, 0);
    checkOutput("rst_peak_count", peak_count, 0);

    // First event and its two-cycle latency.
    applyStimulus(6'd9, 10'd600);
    @(negedge clk);
    checkOutput("lat_edge1_valid", evt_valid, 0);
    checkOutput("lat_fifo_count", fifo_count, 1);
    @(negedge clk);
    checkOutput("lat_edge2_valid", evt_valid, 1);
    waitDrain("drain_first");
    checkOutput("peak_first", peak_count, 16'd1);

    // Hysteresis on ring 1: 520 stays in peak, 490 re-arms, 600 fires.
    applyStimulus(6'd9, 10'd520);
    applyStimulus(6'd9, 10'd490);
    applyStimulus(6'd9, 10'd600);
    waitDrain("drain_hyst");
    checkOutput("peak_hyst", peak_count, mPeak);

    // Exact boundaries: equal to threshold, equal to re-arm level.
    applyConfig(3'd5, 10'd300);
    applyStimulus(6'd40, 10'd300);
    applyStimulus(6'd40, 10'd301);
    applyStimulus(6'd40, 10'd284);
    applyStimulus(6'd40, 10'd301);
    applyStimulus(6'd40, 10'd283);
    applyStimulus(6'd40, 10'd301);
    waitDrain("drain_bounds");

    // Threshold below the hysteresis: re-arm level clamps to zero.
    applyConfig(3'd6, 10'd10);
    applyStimulus(6'd48, 10'd11);
    applyStimulus(6'd48, 10'd0);
    applyStimulus(6'd48, 10'd11);
    waitDrain("drain_clamp");

    // Config write re-arms a ring that is in peak.
    applyStimulus(6'd24, 10'd600);
    waitDrain("drain_ring3_peak");
    applyConfig(3'd3, 10'd100);
    applyStimulus(6'd24, 10'd101);
    applyStimulus(6'd24, 10'd100);
    waitDrain("drain_cfg_rearm");
    checkOutput("peak_cfg", peak_count, mPeak);

    // Back-pressure: fill the FIFO behind a held event, then release.
    for (int r = 0; r < 8; r++) applyConfig(3'(r), 10'd510);
    @(negedge clk);
    evt_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          applyStimulus((i < 8) ? 6'(i * 8 + 2) : 6'((i - 8) * 8 + 5), 10'd700);
        end
      end
      begin
        repeat (25) @(negedge clk);
        checkOutput("full_fifo_count", fifo_count, 8);
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_evt_valid", evt_valid, 1);
        checkOutput("full_evt_channel", evt_channel, 2);
        evt_ready = 1'b1;
        repeat (9) @(negedge clk);
        #2;
        checkOutput("burst_one_per_cycle", sb.size(), 0);
      end
    join
    waitDrain("drain_burst");
    checkOutput("peak_burst", peak_count, mPeak);

    // Reset with a pending event and queued words.
    for (int r = 0; r < 7; r++) applyConfig(3'(r), 10'd510);
    applyConfig(3'd7, 10'd900);
    @(negedge clk);
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(6'(i * 8 + 3), 10'd700);
    @(negedge clk);
    checkOutput("pre_rst_fifo_count", fifo_count, 5);
    checkOutput("pre_rst_evt_valid", evt_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    modelReset();
    evt_ready = 1'b1;
    checkOutput("mid_rst_fifo_count", fifo_count, 0);
    checkOutput("mid_rst_evt_valid", evt_valid, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_evt_value", evt_value, 0);
    checkOutput("mid_rst_peak", peak_count, 0);
    repeat (10) @(negedge clk);
    applyStimulus(6'd16, 10'd510);
    applyStimulus(6'd16, 10'd511);
    applyStimulus(6'd56, 10'd511);
    waitDrain("drain_post_rst");
    checkOutput("peak_post_rst", peak_count, 16'd2);

    // Counter saturation from a preloaded value.
    @(negedge clk);
    force dut.peak_count = 16'hFFFC;
    @(negedge clk);
    release dut.peak_count;
    mPeak = 16'hFFFC;
    applyStimulus(6'd0, 10'd600);
    applyStimulus(6'd8, 10'd600);
    waitDrain("drain_sat1");
    checkOutput("peak_fffe", peak_count, 16'hFFFE);
    applyStimulus(6'd24, 10'd600);
    applyStimulus(6'd32, 10'd600);
    applyStimulus(6'd40, 10'd600);
    waitDrain("drain_sat2");
    checkOutput("peak_saturated", peak_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
